// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction and game-state encodings for the snake pipeline
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'b000,
    DIR_UP    = 3'b001,
    DIR_DOWN  = 3'b010,
    DIR_LEFT  = 3'b011,
    DIR_RIGHT = 3'b100
  } dir_e;

  // 2'b10 is deliberately left unused
  typedef enum logic [1:0] {
    ST_START     = 2'b00,
    ST_PLAY      = 2'b01,
    ST_GAME_OVER = 2'b11
  } state_e;

  // True when b would send the snake straight back into itself from a
  function automatic logic is_reverse(input dir_e a, input dir_e b);
    return ((a == DIR_UP)   && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN) && (b == DIR_UP))    ||
           ((a == DIR_LEFT) && (b == DIR_RIGHT)) ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT));
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop button synchroniser with rising-edge pulse
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Two metastability flops, then one more to remember the previous level
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game FSM, step timing, direction and collision control
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int BIT             = 10,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int BORDER          = 5,
  parameter int FRAMES_PER_STEP = 8,
  parameter int GAMEOVER_FRAMES = 120
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           frame_tick,
  input  logic [BIT-1:0] x_pos,
  input  logic [BIT-1:0] y_pos,
  input  logic           head_active,
  input  logic           body_active,
  output logic [2:0]     direction,
  output logic           update,
  output logic [1:0]     game_state
);

  localparam int STEP_W = $clog2(FRAMES_PER_STEP + 1);
  localparam int GO_W   = $clog2(GAMEOVER_FRAMES + 1);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [GO_W-1:0]   GO_LAST   = GO_W'(GAMEOVER_FRAMES - 1);

  localparam logic [BIT-1:0] X_LO = BIT'(BORDER);
  localparam logic [BIT-1:0] X_HI = BIT'(H_ACTIVE - BORDER);
  localparam logic [BIT-1:0] Y_LO = BIT'(BORDER);
  localparam logic [BIT-1:0] Y_HI = BIT'(V_ACTIVE - BORDER);

  logic up_p;
  logic down_p;
  logic left_p;
  logic right_p;

  btn_sync_edge u_sync_up    (.clk(clk), .reset(reset), .btn_i(btn_up),    .pulse_o(up_p));
  btn_sync_edge u_sync_down  (.clk(clk), .reset(reset), .btn_i(btn_down),  .pulse_o(down_p));
  btn_sync_edge u_sync_left  (.clk(clk), .reset(reset), .btn_i(btn_left),  .pulse_o(left_p));
  btn_sync_edge u_sync_right (.clk(clk), .reset(reset), .btn_i(btn_right), .pulse_o(right_p));

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  dir_e                pend_q, pend_d;
  logic                upd_q, upd_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [GO_W-1:0]     go_q, go_d;
  logic                hit_q, hit_d;
  logic [BIT-1:0]      x_dly_q;
  logic [BIT-1:0]      y_dly_q;

  logic press;
  dir_e press_dir;
  logic wall;
  logic hit_now;
  logic hit_next;

  // Resolve coincident presses with fixed priority UP > DOWN > LEFT > RIGHT
  always_comb begin
    press     = up_p | down_p | left_p | right_p;
    press_dir = DIR_IDLE;
    if (up_p)         press_dir = DIR_UP;
    else if (down_p)  press_dir = DIR_DOWN;
    else if (left_p)  press_dir = DIR_LEFT;
    else if (right_p) press_dir = DIR_RIGHT;
  end

  // Head pixel checks use the delayed scan position so they line up with the renderer flags
  always_comb begin
    wall     = (x_dly_q < X_LO) || (x_dly_q >= X_HI) ||
               (y_dly_q < Y_LO) || (y_dly_q >= Y_HI);
    hit_now  = (state_q == ST_PLAY) && head_active && (body_active || wall);
    hit_next = hit_q || hit_now;
  end

  // State, counters, pending direction, collision latch and scan-position delay
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_START;
      dir_q   <= DIR_IDLE;
      pend_q  <= DIR_IDLE;
      upd_q   <= 1'b0;
      step_q  <= '0;
      go_q    <= '0;
      hit_q   <= 1'b0;
      x_dly_q <= '0;
      y_dly_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      upd_q   <= upd_d;
      step_q  <= step_d;
      go_q    <= go_d;
      hit_q   <= hit_d;
      x_dly_q <= x_pos;
      y_dly_q <= y_pos;
    end
  end

  // Next-state logic: game FSM, step/frame counting, direction commit and hit latch
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    upd_d   = 1'b0;
    step_d  = step_q;
    go_d    = go_q;
    hit_d   = hit_q;

    // Hit is sticky only within one frame of PLAY
    if ((state_q != ST_PLAY) || frame_tick) hit_d = 1'b0;
    else                                    hit_d = hit_next;

    case (state_q)
      ST_START: begin
        dir_d = DIR_IDLE;
        if (press) begin
          pend_d  = press_dir;
          dir_d   = press_dir;
          state_d = ST_PLAY;
          step_d  = '0;
        end
      end

      ST_PLAY: begin
        // Reversal is judged against the committed direction, not the pending one
        if (press && !is_reverse(dir_q, press_dir)) pend_d = press_dir;
        if (frame_tick) begin
          if (hit_next) begin
            state_d = ST_GAME_OVER;
            dir_d   = DIR_IDLE;
            pend_d  = DIR_IDLE;
            go_d    = '0;
            step_d  = '0;
          end else if (step_q == STEP_LAST) begin
            // Commit the old pending value; a press this cycle lands in pend_d for next step
            step_d = '0;
            dir_d  = pend_q;
            upd_d  = 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end

      ST_GAME_OVER: begin
        dir_d  = DIR_IDLE;
        pend_d = DIR_IDLE;
        if (frame_tick) begin
          if (go_q == GO_LAST) begin
            state_d = ST_START;
            go_d    = '0;
          end else begin
            go_d = go_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_START;
        dir_d   = DIR_IDLE;
        pend_d  = DIR_IDLE;
        step_d  = '0;
        go_d    = '0;
      end
    endcase
  end

  assign direction  = dir_q;
  assign update     = upd_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - directed self-checking bench for snake_game_ctrl
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] x_pos = 10'd100;
  logic [9:0] y_pos = 10'd100;
  logic       head_active = 1'b0;
  logic       body_active = 1'b0;
  logic [2:0] direction;
  logic       update;
  logic [1:0] game_state;

  int n_assert = 0;
  int n_fail   = 0;

  snake_game_ctrl dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .frame_tick(frame_tick), .x_pos(x_pos), .y_pos(y_pos),
    .head_active(head_active), .body_active(body_active),
    .direction(direction), .update(update), .game_state(game_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle frame_tick; registered outputs reflect that tick on return
  task automatic ftick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic press(input int which);
    case (which)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      2: btn_left = 1'b1;
      default: btn_right = 1'b1;
    endcase
    repeat (4) step();
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    repeat (4) step();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      ftick();
      step();
      step();
    end
  endtask

  // Tick frames until an update appears (bounded) and return the direction seen with it
  task automatic wait_update(output logic [2:0] d, output logic ok);
    ok = 1'b0;
    d  = 3'b111;
    for (int i = 0; i < 20; i++) begin
      ftick();
      if (update === 1'b1) begin
        d  = direction;
        ok = 1'b1;
        step();
        break;
      end
      step();
      step();
    end
  endtask

  logic [2:0] d_seen;
  logic       ok_seen;
  int         upd_cnt;

  initial begin
    // 1: reset state, START press, first update timing
    step(); step();
    chk("reset_state", 32'(game_state), 32'h0);
    chk("reset_dir", 32'(direction), 32'h0);
    chk("reset_update", 32'(update), 32'h0);
    reset = 1'b0;
    step();

    press(3);
    chk("start_press_state", 32'(game_state), 32'h1);
    chk("start_press_dir", 32'(direction), 32'h4);

    upd_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      ftick();
      if (update === 1'b1) upd_cnt++;
      step();
      if (update === 1'b1) upd_cnt++;
      step();
    end
    chk("no_update_first_7", 32'(upd_cnt), 32'h0);
    ftick();
    chk("update_after_8th", 32'(update), 32'h1);
    chk("dir_during_update", 32'(direction), 32'h4);
    step();
    chk("update_one_cycle", 32'(update), 32'h0);

    // Boundary pixels just inside the wall band are not a hit
    x_pos = 10'd634; y_pos = 10'd474;
    step();
    head_active = 1'b1;
    step();
    x_pos = 10'd5; y_pos = 10'd5;
    step();
    step();
    head_active = 1'b0;
    x_pos = 10'd100; y_pos = 10'd100;
    step();
    ftick();
    chk("inner_edge_no_hit", 32'(game_state), 32'h1);
    step();

    // 2: reverse press ignored, perpendicular press committed
    press(2);
    wait_update(d_seen, ok_seen);
    chk("left_ignored_ok", 32'(ok_seen), 32'h1);
    chk("left_ignored_dir", 32'(d_seen), 32'h4);
    press(0);
    wait_update(d_seen, ok_seen);
    chk("up_commit_ok", 32'(ok_seen), 32'h1);
    chk("up_commit_dir", 32'(d_seen), 32'h1);

    // 3: wall hit mid-frame, game over on the next tick
    x_pos = 10'd2; y_pos = 10'd100;
    step();
    head_active = 1'b1;
    step();
    head_active = 1'b0;
    x_pos = 10'd100;
    step(); step();
    chk("wall_hit_waits_tick", 32'(game_state), 32'h1);
    ftick();
    chk("wall_gameover_state", 32'(game_state), 32'h3);
    chk("wall_gameover_dir", 32'(direction), 32'h0);
    chk("wall_gameover_update", 32'(update), 32'h0);
    step();
    chk("wall_gameover_update2", 32'(update), 32'h0);

    // 5: buttons ignored in GAME_OVER, exact 120-tick hold, restart with DOWN
    press(0);
    chk("go_btn_state", 32'(game_state), 32'h3);
    chk("go_btn_dir", 32'(direction), 32'h0);
    idle_ticks(119);
    chk("go_after_119", 32'(game_state), 32'h3);
    ftick();
    chk("go_after_120", 32'(game_state), 32'h0);
    step();
    press(1);
    chk("restart_state", 32'(game_state), 32'h1);
    chk("restart_dir", 32'(direction), 32'h2);

    // 4: self hit on the frame_tick cycle itself
    idle_ticks(3);
    chk("pre_self_state", 32'(game_state), 32'h1);
    frame_tick = 1'b1; head_active = 1'b1; body_active = 1'b1;
    step();
    frame_tick = 1'b0; head_active = 1'b0; body_active = 1'b0;
    chk("self_hit_state", 32'(game_state), 32'h3);
    chk("self_hit_update", 32'(update), 32'h0);
    step();
    idle_ticks(120);
    chk("back_to_start", 32'(game_state), 32'h0);

    // 6: reset lands on the commit tick; the pending update never appears
    press(3);
    chk("pre_reset_state", 32'(game_state), 32'h1);
    idle_ticks(7);
    frame_tick = 1'b1; reset = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("rst_update", 32'(update), 32'h0);
    chk("rst_state", 32'(game_state), 32'h0);
    chk("rst_dir", 32'(direction), 32'h0);
    step();
    chk("rst_update_next", 32'(update), 32'h0);
    reset = 1'b0;
    step();
    chk("rst_stays_start", 32'(game_state), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
